alu_wide_seq: RTL and testbench
===============================

Name: alu_wide_seq

Overview:
- Initiator/driver for the team's 4-bit combinational ALU: runs one wide operation (NIBBLES×4 bits) as NIBBLES consecutive 4-bit ALU operations, LSB nibble first.
- For arithmetic ops, chains each nibble's carry into the next nibble's c_in.
- Aggregates the ALU's R/zero/carry/sign into wide result and flags.
- Sits between a register-level client (start/ready/done handshake) and one external ALU instance.

Parameters:
NIBBLES, 4, number of 4-bit slices per operation (wide width W = 4*NIBBLES); legal range 2..8

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  request; accepted only when ready=1
op  in  3  ALU opcode; op[2]=0 arithmetic, op[2]=1 logic
a_in  in  W  operand A
b_in  in  W  operand B
cin_in  in  1  carry into nibble 0
ready  out  1  high in IDLE
busy  out  1  high while nibbles are being issued
done  out  1  one-cycle pulse; result/flags valid from this cycle until next accepted start
result  out  W  wide result
zero  out  1  result == 0
carry  out  1  carry out of final nibble
sign  out  1  result[W-1]
alu_a  out  4  to ALU A
alu_b  out  4  to ALU B
alu_cin  out  1  to ALU c_in
alu_op  out  3  to ALU Op
alu_r  in  4  from ALU R
alu_zero  in  1  from ALU zero
alu_carry  in  1  from ALU carry
alu_sign  in  1  from ALU sign

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, nibble index=0, result=0, zero=1, carry=0, sign=0, done=0, busy=0, ready=1, alu_a=alu_b=0, alu_cin=0, alu_op=0. Reset mid-operation aborts it: no done, partial result discarded.
- FSM states:
  - IDLE: start=1 latches a_in, b_in, op, cin_in; idx←0; go to RUN.
  - RUN: for NIBBLES cycles, drive alu_a/alu_b = latched nibble idx, alu_op = latched op, and alu_cin = cin_in for idx 0; for idx>0, the previous alu_carry when op[2]=0, else the latched cin_in. At each edge, capture alu_r into result nibble idx, zero_acc &= alu_zero, carry_reg ← alu_carry, idx++. After the edge with idx=NIBBLES-1, go to DONE.
  - DONE: done=1 for exactly one cycle; result/zero/carry/sign committed; then go to IDLE.
- The ALU is combinational, so each nibble takes one cycle. Latency: start sampled at edge 0 → done high during cycle NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles.
- Final flags:
  - sign = alu_sign of the last nibble.
  - carry = alu_carry of the last nibble, for both arithmetic and logic ops.
  - zero = AND of all nibble alu_zero values.
- Inputs a_in/b_in/op/cin_in are don't-care after acceptance.
- start while not ready is ignored and not queued.
- Outputs result/flags hold their last committed values in IDLE; they update only at entry to DONE.
- alu_* outputs return to 0 in IDLE/DONE.

Optional Feature:
- ALU_WIDE_BACK2BACK_EN defined: start=1 during DONE is accepted (ready=1 in DONE); go directly to RUN. Throughput becomes NIBBLES+1 cycles.
- Undefined: ready=0 in DONE; start there is ignored.

Decomposition:
- Package alu_wide_pkg:
  - NIBBLE_W=4
  - state enum {IDLE, RUN, DONE}
  - OP_ARITH_BIT=2
  - opcode constants OP_ADD=3'b000 and OP_AND=3'b101, used by the bench
- Sub-module alu_wide_nib_sel: selects nibble idx from a W-bit vector.
- The ALU itself is instantiated only in the testbench/top, never inside this block.

Test Plan:
- NIBBLES=4, OP_ADD, a=16'h0FFF, b=16'h0001, cin=0 → done at cycle 5 after start; result=16'h1000, carry=0, zero=0, sign=1? No: sign=0.
- OP_ADD, a=16'hFFFF, b=16'h0001, cin=0 → result=16'h0000, carry=1, zero=1, sign=0; alu_cin observed 0,1,1,1 across nibbles.
- OP_AND, a=16'hF0F0, b=16'h0FF0, cin=1 → result=16'h00F0, zero=0, sign=0; alu_cin=1 for every nibble.
- Start asserted in RUN cycle 2 with different operands → ignored; first op's result unchanged; ready=0 throughout RUN.
- reset_n=0 in RUN cycle 2 of OP_ADD 16'h1234+16'h1111 → next cycle IDLE, ready=1, result=0, zero=1, no done pulse.
- With ALU_WIDE_BACK2BACK_EN: start held high continuously → done pulses every 5 cycles; without the macro → every 6 cycles.

Source files
------------

// File: rtl/alu_wide_pkg.sv
// -----------------------------------------------------------------------------
// alu_wide_pkg
//   Shared types and constants for the wide sequential ALU driver.
//   - NIBBLE_W     : width of one ALU slice (the external ALU is 4 bits wide)
//   - state_t      : sequencer states IDLE / RUN / DONE
//   - OP_ARITH_BIT : opcode bit that selects logic (1) or arithmetic (0)
//   - OP_ADD/OP_AND: named opcodes of the external ALU
//   - is_arith()   : opcode class helper
// -----------------------------------------------------------------------------
package alu_wide_pkg;

  localparam int NIBBLE_W     = 4;
  localparam int OP_ARITH_BIT = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic ops chain carries between nibbles; logic ops do not.
  function automatic logic is_arith(input logic [2:0] op);
    return (op[OP_ARITH_BIT] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_wide_nib_sel.sv
// -----------------------------------------------------------------------------
// alu_wide_nib_sel
//   Picks nibble i_idx out of a NIBBLES*4-bit vector. Index values past the
//   last nibble return 4'h0 (the vector is zero-padded up to a power-of-two
//   number of slots so the select never reads outside the vector).
//
//   Ports:
//     i_vec  in  NIBBLES*4  source vector
//     i_idx  in  IDX_W      nibble index (0 = least significant nibble)
//     o_nib  out 4          selected nibble
// -----------------------------------------------------------------------------
module alu_wide_nib_sel
  import alu_wide_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = $clog2(NIBBLES)
) (
  input  logic [NIBBLES*NIBBLE_W-1:0] i_vec,
  input  logic [IDX_W-1:0]            i_idx,
  output logic [NIBBLE_W-1:0]         o_nib
);

  localparam int SLOTS = 1 << IDX_W;

  logic [SLOTS*NIBBLE_W-1:0] w_pad;

  // Zero-pad the source to SLOTS nibbles, then index it by i_idx*4.
  always_comb begin
    w_pad                           = '0;
    w_pad[NIBBLES*NIBBLE_W-1:0]     = i_vec;
    o_nib                           = w_pad[{i_idx, 2'b00} +: NIBBLE_W];
  end

endmodule

// File: rtl/alu_wide_seq.sv
// -----------------------------------------------------------------------------
// alu_wide_seq
//   Runs one NIBBLES*4-bit operation on an external 4-bit combinational ALU by
//   issuing NIBBLES consecutive nibble operations, least significant first.
//   Arithmetic ops feed each nibble's carry-out into the next nibble's carry-in;
//   logic ops give every nibble the latched cin_in. Nibble results are gathered
//   into a wide result and the flags are aggregated:
//     zero  = AND of all nibble zero flags
//     carry = carry-out of the last nibble
//     sign  = sign of the last nibble
//   Latency: start accepted at edge 0, done is high in the cycle after edge
//   NIBBLES. Committed result/flags change only when DONE is entered.
//
//   Configuration macro:
//     ALU_WIDE_BACK2BACK_EN  when defined, ready is also high in DONE and a
//                            start there goes straight to RUN (one op every
//                            NIBBLES+1 cycles instead of NIBBLES+2).
//
//   Ports:
//     clk        in  1  clock, rising edge
//     reset_n    in  1  synchronous active-low reset
//     start      in  1  request, taken only while ready=1
//     op         in  3  ALU opcode (op[2]=0 arithmetic, op[2]=1 logic)
//     a_in,b_in  in  W  wide operands
//     cin_in     in  1  carry into nibble 0
//     ready      out 1  can accept start
//     busy       out 1  nibbles being issued
//     done       out 1  one-cycle completion pulse
//     result     out W  wide result
//     zero,carry,sign out 1 wide flags
//     alu_a,alu_b,alu_cin,alu_op  out  operands to the external ALU
//     alu_r,alu_zero,alu_carry,alu_sign in  results from the external ALU
// -----------------------------------------------------------------------------
module alu_wide_seq
  import alu_wide_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [NIBBLES*NIBBLE_W-1:0] a_in,
  input  logic [NIBBLES*NIBBLE_W-1:0] b_in,
  input  logic                        cin_in,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLES*NIBBLE_W-1:0] result,
  output logic                        zero,
  output logic                        carry,
  output logic                        sign,
  output logic [NIBBLE_W-1:0]         alu_a,
  output logic [NIBBLE_W-1:0]         alu_b,
  output logic                        alu_cin,
  output logic [2:0]                  alu_op,
  input  logic [NIBBLE_W-1:0]         alu_r,
  input  logic                        alu_zero,
  input  logic                        alu_carry,
  input  logic                        alu_sign
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

`ifdef ALU_WIDE_BACK2BACK_EN
  localparam logic DONE_READY = 1'b1;
`else
  localparam logic DONE_READY = 1'b0;
`endif

  // Sequencer state and latched request
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2:0]       r_op;
  logic             r_cin;

  // Work-in-progress accumulators (not visible until DONE)
  logic [W-1:0]     r_acc;
  logic             r_zero_acc;

  // Registered outputs
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_sign;
  logic [NIBBLE_W-1:0] r_alu_a;
  logic [NIBBLE_W-1:0] r_alu_b;
  logic             r_alu_cin;
  logic [2:0]       r_alu_op;

  // Combinational helpers
  logic             w_accept;
  logic [IDX_W-1:0] w_idx_next;
  logic [NIBBLE_W-1:0] w_a_nib_next;
  logic [NIBBLE_W-1:0] w_b_nib_next;
  logic [W-1:0]     w_acc_next;
  logic             w_zero_next;
  logic             w_cin_next;

  // ready is only ever high in IDLE (and in DONE when back-to-back is built in)
  assign w_accept   = start & r_ready;
  assign w_idx_next = r_idx + IDX_W'(1);

  // Operand nibbles for the cycle after the current one
  alu_wide_nib_sel #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_sel_a (
    .i_vec (r_a),
    .i_idx (w_idx_next),
    .o_nib (w_a_nib_next)
  );

  alu_wide_nib_sel #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_sel_b (
    .i_vec (r_b),
    .i_idx (w_idx_next),
    .o_nib (w_b_nib_next)
  );

  // Merge the current ALU nibble into the accumulators and pick the next carry-in
  always_comb begin
    w_acc_next                              = r_acc;
    w_acc_next[{r_idx, 2'b00} +: NIBBLE_W]  = alu_r;
    w_zero_next                             = r_zero_acc & alu_zero;
    if (is_arith(r_op)) begin
      w_cin_next = alu_carry;
    end else begin
      w_cin_next = r_cin;
    end
  end

  // Sequencer: accept, issue nibbles, commit, and drive all registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'b000;
      r_cin      <= 1'b0;
      r_acc      <= '0;
      r_zero_acc <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_carry    <= 1'b0;
      r_sign     <= 1'b0;
      r_alu_a    <= 4'h0;
      r_alu_b    <= 4'h0;
      r_alu_cin  <= 1'b0;
      r_alu_op   <= 3'b000;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Latch the request and present nibble 0 to the ALU straight away
        r_a        <= a_in;
        r_b        <= b_in;
        r_op       <= op;
        r_cin      <= cin_in;
        r_idx      <= '0;
        r_acc      <= '0;
        r_zero_acc <= 1'b1;
        r_state    <= RUN;
        r_ready    <= 1'b0;
        r_busy     <= 1'b1;
        r_alu_a    <= a_in[NIBBLE_W-1:0];
        r_alu_b    <= b_in[NIBBLE_W-1:0];
        r_alu_op   <= op;
        r_alu_cin  <= cin_in;
      end else begin
        case (r_state)
          IDLE: begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
          RUN: begin
            r_acc      <= w_acc_next;
            r_zero_acc <= w_zero_next;
            r_idx      <= w_idx_next;
            if (r_idx == LAST_IDX) begin
              // Last nibble: commit the wide result and flags together
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_ready   <= DONE_READY;
              r_result  <= w_acc_next;
              r_zero    <= w_zero_next;
              r_carry   <= alu_carry;
              r_sign    <= alu_sign;
              r_alu_a   <= 4'h0;
              r_alu_b   <= 4'h0;
              r_alu_cin <= 1'b0;
              r_alu_op  <= 3'b000;
            end else begin
              r_alu_a   <= w_a_nib_next;
              r_alu_b   <= w_b_nib_next;
              r_alu_cin <= w_cin_next;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
          default: begin
            // Unreachable encoding: fall back to a clean idle
            r_state   <= IDLE;
            r_idx     <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_alu_a   <= 4'h0;
            r_alu_b   <= 4'h0;
            r_alu_cin <= 1'b0;
            r_alu_op  <= 3'b000;
          end
        endcase
      end
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign zero    = r_zero;
  assign carry   = r_carry;
  assign sign    = r_sign;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_cin = r_alu_cin;
  assign alu_op  = r_alu_op;

endmodule

// File: tb/tb_alu_wide_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_seq
//   Bench for alu_wide_seq with NIBBLES=4. Provides the external 4-bit ALU,
//   a wide reference model (plain W-bit arithmetic), directed cases and a
//   randomized loop. Honours ALU_WIDE_BACK2BACK_EN for the DONE-state
//   ready/throughput expectations.
//
//   Bench ALU opcodes: 000 a+b+c, 001 a+~b+c, 010 a+c, 011 ~a+b+c,
//                      100 a|b, 101 a&b, 110 a^b, 111 ~(a|b) (carry = c_in)
// -----------------------------------------------------------------------------
module tb_alu_wide_seq;
  import alu_wide_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;
`ifdef ALU_WIDE_BACK2BACK_EN
  localparam logic DONE_READY = 1'b1;
  localparam int   PERIOD     = N + 1;
`else
  localparam logic DONE_READY = 1'b0;
  localparam int   PERIOD     = N + 2;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic         ready, busy, done, zero, carry, sign;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_r;
  logic         alu_cin, alu_zero, alu_carry, alu_sign;
  logic [2:0]   alu_op;
  logic [4:0]   alu_s;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_wide_seq #(.NIBBLES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .zero(zero), .carry(carry), .sign(sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign)
  );

  // External combinational 4-bit ALU
  always_comb begin
    alu_s = 5'd0;
    case (alu_op)
      3'b000:  alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
      3'b001:  alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
      3'b010:  alu_s = {1'b0, alu_a} + {4'd0, alu_cin};
      3'b011:  alu_s = {1'b0, ~alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
      3'b100:  alu_s = {alu_cin, alu_a | alu_b};
      3'b101:  alu_s = {alu_cin, alu_a & alu_b};
      3'b110:  alu_s = {alu_cin, alu_a ^ alu_b};
      default: alu_s = {alu_cin, ~(alu_a | alu_b)};
    endcase
    alu_r     = alu_s[3:0];
    alu_carry = alu_s[4];
    alu_zero  = (alu_s[3:0] == 4'h0);
    alu_sign  = alu_s[3];
  end

  // Wide-level operand transform for arithmetic ops
  function automatic void arith_words(input logic [W-1:0] a, b, input logic [2:0] o,
                                      output longint unsigned aw, bw);
    aw = 64'(a);
    bw = 64'(b);
    case (o[1:0])
      2'b01:   bw = 64'(W'(~b));
      2'b10:   bw = 64'd0;
      2'b11:   aw = 64'(W'(~a));
      default: bw = 64'(b);
    endcase
  endfunction

  // Reference: {carry, result} of the whole W-bit operation
  function automatic logic [W:0] ref_wide(input logic [W-1:0] a, b, input logic [2:0] o,
                                          input logic c);
    longint unsigned aw, bw;
    if (o[2] == 1'b0) begin
      arith_words(a, b, o, aw, bw);
      return (W+1)'(aw + bw + 64'(c));
    end
    case (o[1:0])
      2'b00:   return {c, a | b};
      2'b01:   return {c, a & b};
      2'b10:   return {c, a ^ b};
      default: return {c, ~(a | b)};
    endcase
  endfunction

  // Reference: carry entering nibble k
  function automatic logic ref_cin(input logic [W-1:0] a, b, input logic [2:0] o,
                                   input logic c, input int k);
    longint unsigned aw, bw, mask;
    if (k == 0 || o[2] == 1'b1) return c;
    arith_words(a, b, o, aw, bw);
    mask = (64'd1 << (4 * k)) - 64'd1;
    return 1'(((aw & mask) + (bw & mask) + 64'(c)) >> (4 * k));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation; called and returning at a negedge with the DUT idle
  task automatic run_op(input logic [W-1:0] a, b, input logic [2:0] o, input logic c,
                        input bit poke);
    logic [W:0] exp;
    logic [W:0] held;
    exp = ref_wide(a, b, o, c);
    a_in = a; b_in = b; op = o; cin_in = c; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= N; cyc++) begin
      @(negedge clk);
      check("run_busy",  64'(busy),  64'd1);
      check("run_ready", 64'(ready), 64'd0);
      check("run_done",  64'(done),  64'd0);
      check("alu_op",    64'(alu_op), 64'(o));
      check("alu_a",     64'(alu_a),  64'((a >> (4 * (cyc - 1))) & W'(4'hF)));
      check("alu_b",     64'(alu_b),  64'((b >> (4 * (cyc - 1))) & W'(4'hF)));
      check("alu_cin",   64'(alu_cin), 64'(ref_cin(a, b, o, c, cyc - 1)));
      // Inputs are don't-care after acceptance
      a_in = W'($urandom); b_in = W'($urandom); op = 3'($urandom); cin_in = 1'($urandom);
      start = (poke && cyc == 2) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 64'(done),   64'd1);
    check("done_busy",  64'(busy),   64'd0);
    check("done_ready", 64'(ready),  64'(DONE_READY));
    check("result",     64'(result), 64'(exp[W-1:0]));
    check("carry",      64'(carry),  64'(exp[W]));
    check("zero",       64'(zero),   64'(exp[W-1:0] == '0));
    check("sign",       64'(sign),   64'(exp[W-1]));
    check("done_alu_a", 64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
    held = {carry, result};
    @(negedge clk);
    check("idle_done",   64'(done),  64'd0);
    check("idle_ready",  64'(ready), 64'd1);
    check("idle_hold",   64'({carry, result}), 64'(held));
    check("idle_alu",    64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
  endtask

  initial begin
    int done_cyc[$];
    int pulses;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(ready),  64'd1);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags",  64'({zero, carry, sign}), 64'b100);
    check("rst_alu",    64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(16'h0FFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
    check("dir_0fff", 64'(result), 64'h1000);
    run_op(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
    check("dir_ffff", 64'({carry, zero, result}), 64'h3_0000);
    run_op(16'h8000, 16'h8000, OP_ADD, 1'b1, 1'b0);
    run_op(16'h1234, 16'h1234, 3'b001, 1'b1, 1'b0);
    run_op(16'hF0F0, 16'h0FF0, OP_AND, 1'b1, 1'b1);
    check("dir_and", 64'(result), 64'h00F0);

    // Randomized operations, some with an ignored start poked mid-run
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset during RUN aborts the operation
    a_in = 16'h1234; b_in = 16'h1111; op = OP_ADD; cin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    check("abort_ready",  64'(ready),  64'd1);
    check("abort_busy",   64'(busy),   64'd0);
    check("abort_done",   64'(done),   64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero",   64'(zero),   64'd1);
    check("abort_alu",    64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
    reset_n = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < N + 3; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    // Throughput with start held high
    a_in = 16'h0101; b_in = 16'h0202; op = OP_ADD; cin_in = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 5 * PERIOD; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) done_cyc.push_back(cyc);
    end
    start = 1'b0;
    check("tput_pulses", 64'(done_cyc.size() >= 4), 64'd1);
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("tput_period", 64'(done_cyc[i] - done_cyc[i-1]), 64'(PERIOD));
    end
    check("tput_result", 64'(result), 64'h0303);
    repeat (2 * N + 4) @(negedge clk);
    check("final_ready", 64'(ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
